// File: rtl/param_queue_pkg.sv
// Shared definitions for param_queue: depth and count-width helpers
// and the parameter legality predicate.
package param_queue_pkg;

    function automatic int unsigned depth(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned aw);
        return aw + 1;
    endfunction

    function automatic bit params_legal(input int unsigned w, input int unsigned aw,
                                        input int unsigned af, input int unsigned ae);
        return (w >= 1) && (aw >= 1) && (af >= 1) && (af <= depth(aw)) &&
               (ae <= depth(aw) - 1);
    endfunction

endpackage

// File: rtl/param_queue_ram.sv
// Storage array for param_queue: synchronous write port, asynchronous read port.
module param_queue_ram
    import param_queue_pkg::*;
#(
    parameter int unsigned W  = 8,
    parameter int unsigned AW = 4
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] wa_i,
    input  logic [W-1:0]  di_i,
    input  logic [AW-1:0] ra_i,
    output logic [W-1:0]  do_o
);

    localparam int unsigned D = depth(AW);

    logic [W-1:0] mem_q [D];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[wa_i] <= di_i;
        end
    end

    assign do_o = mem_q[ra_i];

endmodule

// File: rtl/param_queue.sv
// Parametrised ring-buffer FIFO with occupancy count, threshold flags,
// registered read data with valid strobe, and sticky overflow/underflow flags.
module param_queue
    import param_queue_pkg::*;
#(
    parameter int unsigned W      = 8,
    parameter int unsigned AW     = 4,
    parameter int unsigned AF_LVL = 14,
    parameter int unsigned AE_LVL = 2
) (
    input  logic             clk_i,
    input  logic             init_i,
    input  logic             wr_i,
    input  logic             rd_i,
    input  logic             clr_err_i,
    input  logic [W-1:0]     di_i,
    output logic [W-1:0]     dq_o,
    output logic             dv_o,
    output logic [AW:0]      count_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             afull_o,
    output logic             aempty_o,
    output logic             ovf_o,
    output logic             udf_o
);

    localparam int unsigned D  = depth(AW);
    localparam int unsigned CW = cnt_width(AW);

    if (!params_legal(W, AW, AF_LVL, AE_LVL)) begin : gen_bad_params
        $error("param_queue: AF_LVL must be 1..2**AW and AE_LVL 0..2**AW-1");
    end

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [W-1:0]  dq_q, dq_d;
    logic          dv_q, dv_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;
    logic [W-1:0]  ram_rdata;
    logic          empty, full;
    logic          wr_ok, rd_ok;

    // Status flags decode only the count register, never the request inputs.
    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(D));

    // A read frees a slot on the same edge, so a full queue still takes a write.
    assign wr_ok = wr_i & (~full | rd_i);
    assign rd_ok = rd_i & ~empty;

    param_queue_ram #(
        .W  (W),
        .AW (AW)
    ) u_ram (
        .clk_i (clk_i),
        .we_i  (wr_ok),
        .wa_i  (wptr_q),
        .di_i  (di_i),
        .ra_i  (rptr_q),
        .do_o  (ram_rdata)
    );

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        dq_d    = dq_q;
        dv_d    = rd_ok;
        if (wr_ok) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (rd_ok) begin
            rptr_d = rptr_q + AW'(1);
            dq_d   = ram_rdata;
        end
        unique case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // A fresh error on the clearing edge wins over the clear.
        ovf_d = (ovf_q & ~clr_err_i) | (wr_i & full & ~rd_i);
        udf_d = (udf_q & ~clr_err_i) | (rd_i & empty);
    end

    always_ff @(posedge clk_i) begin
        if (init_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            dq_q    <= '0;
            dv_q    <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            dq_q    <= dq_d;
            dv_q    <= dv_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    assign dq_o     = dq_q;
    assign dv_o     = dv_q;
    assign count_o  = count_q;
    assign empty_o  = empty;
    assign full_o   = full;
    assign afull_o  = (count_q >= CW'(AF_LVL));
    assign aempty_o = (count_q <= CW'(AE_LVL));
    assign ovf_o    = ovf_q;
    assign udf_o    = udf_q;

endmodule

// File: tb/tb_param_queue.sv
// Bench for param_queue: directed scenarios on the default configuration plus
// randomised traffic on two corner configurations, all checked against a queue model.
module tb_param_queue;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        init_s [3];
    logic        wr_s   [3];
    logic        rd_s   [3];
    logic        clr_s  [3];
    logic [31:0] di_s   [3];

    logic [7:0]  dq0;  logic [4:0] cnt0;
    logic        dv0, e0, f0, af0, ae0, ov0, ud0;
    logic [0:0]  dq1;  logic [1:0] cnt1;
    logic        dv1, e1, f1, af1, ae1, ov1, ud1;
    logic [15:0] dq2;  logic [5:0] cnt2;
    logic        dv2, e2, f2, af2, ae2, ov2, ud2;

    param_queue #(.W(8), .AW(4), .AF_LVL(14), .AE_LVL(2)) u_dut0 (
        .clk_i(clk), .init_i(init_s[0]), .wr_i(wr_s[0]), .rd_i(rd_s[0]),
        .clr_err_i(clr_s[0]), .di_i(di_s[0][7:0]), .dq_o(dq0), .dv_o(dv0),
        .count_o(cnt0), .empty_o(e0), .full_o(f0), .afull_o(af0), .aempty_o(ae0),
        .ovf_o(ov0), .udf_o(ud0)
    );

    param_queue #(.W(1), .AW(1), .AF_LVL(2), .AE_LVL(0)) u_dut1 (
        .clk_i(clk), .init_i(init_s[1]), .wr_i(wr_s[1]), .rd_i(rd_s[1]),
        .clr_err_i(clr_s[1]), .di_i(di_s[1][0:0]), .dq_o(dq1), .dv_o(dv1),
        .count_o(cnt1), .empty_o(e1), .full_o(f1), .afull_o(af1), .aempty_o(ae1),
        .ovf_o(ov1), .udf_o(ud1)
    );

    param_queue #(.W(16), .AW(5), .AF_LVL(32), .AE_LVL(0)) u_dut2 (
        .clk_i(clk), .init_i(init_s[2]), .wr_i(wr_s[2]), .rd_i(rd_s[2]),
        .clr_err_i(clr_s[2]), .di_i(di_s[2][15:0]), .dq_o(dq2), .dv_o(dv2),
        .count_o(cnt2), .empty_o(e2), .full_o(f2), .afull_o(af2), .aempty_o(ae2),
        .ovf_o(ov2), .udf_o(ud2)
    );

    int checks   = 0;
    int failures = 0;

    // Model: a plain FIFO list per instance plus output registers.
    int          dep [3] = '{16, 2, 32};
    int          afl [3] = '{14, 2, 32};
    int          ael [3] = '{2, 0, 0};
    logic [31:0] msk [3] = '{32'hFF, 32'h1, 32'hFFFF};
    int          mq  [3][$];
    int          m_dq  [3];
    bit          m_dv  [3];
    bit          m_ovf [3];
    bit          m_udf [3];
    bit          valid [3] = '{0, 0, 0};

    task automatic cmp(input string nm, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%0h want=%0h at %0t", nm, k, act, exp, $time);
        end
    endtask

    task automatic model_step(input int k);
        int n;
        bit full, empty, wok, rok;
        if (init_s[k]) begin
            mq[k].delete();
            m_dq[k]  = 0;
            m_dv[k]  = 0;
            m_ovf[k] = 0;
            m_udf[k] = 0;
            valid[k] = 1;
        end else if (valid[k]) begin
            n     = mq[k].size();
            full  = (n == dep[k]);
            empty = (n == 0);
            wok   = wr_s[k] && (!full || rd_s[k]);
            rok   = rd_s[k] && !empty;
            m_dv[k] = rok;
            if (rok) m_dq[k] = mq[k].pop_front();
            if (wok) mq[k].push_back(int'(di_s[k] & msk[k]));
            if (clr_s[k]) begin
                m_ovf[k] = 0;
                m_udf[k] = 0;
            end
            if (wr_s[k] && full && !rd_s[k]) m_ovf[k] = 1;
            if (rd_s[k] && empty) m_udf[k] = 1;
        end
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) model_step(k);
    end

    task automatic check_inst(input int k, input logic [31:0] dq, input logic [31:0] cnt,
                              input logic dv, input logic e, input logic f, input logic af,
                              input logic ae, input logic ov, input logic ud);
        int n;
        n = mq[k].size();
        cmp("count", k, cnt, n);
        cmp("empty", k, 32'(e), 32'(n == 0));
        cmp("full", k, 32'(f), 32'(n == dep[k]));
        cmp("afull", k, 32'(af), 32'(n >= afl[k]));
        cmp("aempty", k, 32'(ae), 32'(n <= ael[k]));
        cmp("dv", k, 32'(dv), 32'(m_dv[k]));
        cmp("dq", k, dq, m_dq[k]);
        cmp("ovf", k, 32'(ov), 32'(m_ovf[k]));
        cmp("udf", k, 32'(ud), 32'(m_udf[k]));
    endtask

    always @(negedge clk) begin
        if (valid[0]) check_inst(0, 32'(dq0), 32'(cnt0), dv0, e0, f0, af0, ae0, ov0, ud0);
        if (valid[1]) check_inst(1, 32'(dq1), 32'(cnt1), dv1, e1, f1, af1, ae1, ov1, ud1);
        if (valid[2]) check_inst(2, 32'(dq2), 32'(cnt2), dv2, e2, f2, af2, ae2, ov2, ud2);
    end

    task automatic drv(input bit i, input bit w, input bit r, input bit c,
                       input logic [31:0] d);
        init_s[0] = i;
        wr_s[0]   = w;
        rd_s[0]   = r;
        clr_s[0]  = c;
        di_s[0]   = d;
        @(posedge clk);
        #1;
    endtask

    task automatic directed();
        // Reset and fill
        drv(1, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0);
        cmp("rst_count", 0, 32'(cnt0), 0);
        cmp("rst_empty", 0, 32'(e0), 1);
        cmp("rst_aempty", 0, 32'(ae0), 1);
        cmp("rst_full", 0, 32'(f0), 0);
        cmp("rst_afull", 0, 32'(af0), 0);
        cmp("rst_dv", 0, 32'(dv0), 0);
        cmp("rst_dq", 0, 32'(dq0), 0);
        cmp("rst_ovf", 0, 32'(ov0), 0);
        cmp("rst_udf", 0, 32'(ud0), 0);
        for (int i = 1; i <= 16; i++) begin
            drv(0, 1, 0, 0, i);
            cmp("fill_count", 0, 32'(cnt0), i);
            cmp("fill_afull", 0, 32'(af0), 32'(i >= 14));
        end
        cmp("fill_full", 0, 32'(f0), 1);
        cmp("fill_empty", 0, 32'(e0), 0);
        cmp("fill_ovf", 0, 32'(ov0), 0);
        // Overflow
        for (int i = 0; i < 3; i++) begin
            drv(0, 1, 0, 0, 32'hAA);
            cmp("ovf_flag", 0, 32'(ov0), 1);
            cmp("ovf_count", 0, 32'(cnt0), 16);
        end
        for (int i = 1; i <= 16; i++) begin
            drv(0, 0, 1, 0, 0);
            cmp("drain_dv", 0, 32'(dv0), 1);
            cmp("drain_dq", 0, 32'(dq0), i);
        end
        cmp("drain_empty", 0, 32'(e0), 1);
        // Underflow
        for (int i = 0; i < 2; i++) begin
            drv(0, 0, 1, 0, 0);
            cmp("udf_flag", 0, 32'(ud0), 1);
            cmp("udf_dv", 0, 32'(dv0), 0);
            cmp("udf_dq_hold", 0, 32'(dq0), 16);
        end
        drv(0, 0, 0, 1, 0);
        cmp("clr_udf", 0, 32'(ud0), 0);
        cmp("clr_ovf", 0, 32'(ov0), 0);
        // Interleaved across pointer wrap
        drv(0, 1, 0, 0, 100);
        for (int i = 1; i < 20; i++) begin
            drv(0, 1, 1, 0, 100 + i);
            cmp("wrap_dq", 0, 32'(dq0), 100 + i - 1);
            cmp("wrap_dv", 0, 32'(dv0), 1);
        end
        drv(0, 0, 1, 0, 0);
        cmp("wrap_last", 0, 32'(dq0), 119);
        cmp("wrap_empty", 0, 32'(e0), 1);
        // Simultaneous at full
        for (int i = 0; i < 16; i++) drv(0, 1, 0, 0, i);
        drv(0, 1, 1, 0, 32'h55);
        cmp("fullrw_count", 0, 32'(cnt0), 16);
        cmp("fullrw_full", 0, 32'(f0), 1);
        cmp("fullrw_ovf", 0, 32'(ov0), 0);
        cmp("fullrw_dq", 0, 32'(dq0), 0);
        for (int i = 1; i <= 16; i++) begin
            drv(0, 0, 1, 0, 0);
            cmp("fullrw_order", 0, 32'(dq0), (i < 16) ? i : 32'h55);
        end
        cmp("fullrw_empty", 0, 32'(e0), 1);
        // Simultaneous at empty
        drv(0, 1, 1, 0, 32'h33);
        cmp("emptyrw_count", 0, 32'(cnt0), 1);
        cmp("emptyrw_udf", 0, 32'(ud0), 1);
        cmp("emptyrw_dv", 0, 32'(dv0), 0);
        drv(0, 0, 1, 0, 0);
        cmp("emptyrw_dq", 0, 32'(dq0), 32'h33);
        cmp("emptyrw_dv2", 0, 32'(dv0), 1);
        // Reset mid-operation, udf still set from above
        for (int i = 0; i < 7; i++) drv(0, 1, 0, 0, 32'h10 + i);
        cmp("mid_count7", 0, 32'(cnt0), 7);
        drv(1, 1, 1, 0, 32'h99);
        cmp("mid_count", 0, 32'(cnt0), 0);
        cmp("mid_empty", 0, 32'(e0), 1);
        cmp("mid_dv", 0, 32'(dv0), 0);
        cmp("mid_dq", 0, 32'(dq0), 0);
        cmp("mid_ovf", 0, 32'(ov0), 0);
        cmp("mid_udf", 0, 32'(ud0), 0);
        drv(0, 1, 0, 0, 32'h5A);
        drv(0, 0, 1, 0, 0);
        cmp("mid_dq5a", 0, 32'(dq0), 32'h5A);
        cmp("mid_dv5a", 0, 32'(dv0), 1);
        drv(0, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 0);
    endtask

    task automatic randomised();
        int bias;
        @(posedge clk);
        #1;
        for (int k = 1; k < 3; k++) init_s[k] = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c < 2000; c++) begin
            // Alternate fill-heavy and drain-heavy phases to reach both boundaries.
            bias = ((c / 100) % 2 == 1) ? 75 : 25;
            for (int k = 1; k < 3; k++) begin
                init_s[k] = ($urandom_range(499) == 0);
                wr_s[k]   = ($urandom_range(99) < bias);
                rd_s[k]   = ($urandom_range(99) >= bias);
                clr_s[k]  = ($urandom_range(19) == 0);
                di_s[k]   = $urandom;
            end
            @(posedge clk);
            #1;
        end
        for (int k = 1; k < 3; k++) begin
            wr_s[k] = 1'b0;
            rd_s[k] = 1'b0;
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            init_s[k] = 1'b1;
            wr_s[k]   = 1'b0;
            rd_s[k]   = 1'b0;
            clr_s[k]  = 1'b0;
            di_s[k]   = '0;
        end
        fork
            directed();
            randomised();
        join
        @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/param_queue.md
Name: param_queue

Overview:
Parametrised synchronous ring-buffer FIFO, the next generation of the team's 16x8 queue. Adds the following over the fixed-size queue:
- configurable data width and depth
- occupancy count output
- programmable almost-full and almost-empty thresholds
- registered read data with a valid strobe
- sticky overflow and underflow error flags

Used as the standard inter-stage buffer in lab datapaths.

Parameters:
W, 8, data width in bits (>=1)
AW, 4, address width; depth D = 2**AW entries (AW>=1)
AF_LVL, 14, AFULL asserted when COUNT >= AF_LVL (1..D)
AE_LVL, 2, AEMPTY asserted when COUNT <= AE_LVL (0..D-1)

Ports:
CLK  in  1  clock, all state changes on rising edge
INIT  in  1  synchronous active-high reset
WR  in  1  write request
RD  in  1  read request
CLR_ERR  in  1  synchronous clear of OVF/UDF
DI  in  W  write data
DQ  out  W  registered read data
DV  out  1  DQ valid, one-cycle pulse
COUNT  out  AW+1  number of stored entries, 0..D
EMPTY  out  1  COUNT==0
FULL  out  1  COUNT==D
AFULL  out  1  COUNT>=AF_LVL
AEMPTY  out  1  COUNT<=AE_LVL
OVF  out  1  sticky: write attempted while full and not accepted
UDF  out  1  sticky: read attempted while empty

Behaviour:
- Reset: one clock and one synchronous active-high reset (CLK, INIT). INIT=1 at a rising edge has the following effects:
  - write pointer, read pointer and COUNT go to 0
  - EMPTY=1, AEMPTY=1, FULL=0, AFULL=0 (AFULL=1 only if AF_LVL==0, which is illegal)
  - DQ=0, DV=0, OVF=0, UDF=0
  - RAM contents are not cleared.
  - INIT has priority over WR, RD and CLR_ERR, including mid-operation; all data in flight is discarded.
- Accept rules, evaluated each edge on the pre-edge state:
  - wr_ok = WR & (~FULL | RD)
  - rd_ok = RD & ~EMPTY
- Simultaneous WR and RD:
  - Full: both are accepted and COUNT is unchanged. FULL stays 1 and OVF is not set.
  - Empty: the write is accepted, the read is rejected and UDF is set. COUNT becomes 1.
  - Otherwise: both are accepted and COUNT is unchanged.
- Write: when wr_ok, mem[wptr] <= DI and wptr <= wptr+1 mod D (natural AW-bit wrap).
- Read: when rd_ok, DQ <= mem[rptr] on the same edge, DV=1 for exactly that next cycle, and rptr <= rptr+1 mod D.
  - Read latency is 1 cycle from the sampled RD to DQ/DV.
  - DQ holds its value when there is no read; DV=0 otherwise.
- Count: COUNT <= COUNT + wr_ok - rd_ok. COUNT never exceeds D and never goes below 0.
- Status flags: EMPTY, FULL, AFULL and AEMPTY are decoded from the COUNT register. They have no combinational path from WR/RD/DI and change on the same edge as COUNT.
- Error flags:
  - OVF <= 1 when WR & FULL & ~RD.
  - UDF <= 1 when RD & EMPTY.
  - Both are sticky until CLR_ERR or INIT.
  - If CLR_ERR and a new error occur on the same edge, the new error wins (flag = 1).
- Data ordering: strict FIFO order. Rejected operations change no pointer, no COUNT and no RAM entry.
- Parameter checks: an elaboration-time check rejects AF_LVL outside 1..D and AE_LVL outside 0..D-1.

Decomposition:
- Shared package/header:
  - depth function D=2**AW
  - COUNT width AW+1
  - parameter legality checks
- One sub-module: queue_ram (parameters W, AW; synchronous write with WE/WA/DI, asynchronous read with RA/DO). The top holds the pointers, counter, flags and DQ register.

Test Plan:
1. Reset and fill: INIT for 2 cycles, then write DI=1..16, one per cycle. COUNT steps 0->16 and AFULL rises when COUNT=14. FULL=1 after the 16th write and EMPTY=0. OVF stays 0.
2. Overflow: with the queue full, WR=1 with DI=0xAA for 3 cycles and RD=0. COUNT stays 16 and OVF=1 from the first attempt. A full drain then returns 1..16 in order, with 0xAA absent.
3. Underflow and wrap: drain 16 entries; DV pulses 16 times and EMPTY=1 after the last read. RD=1 for 2 more cycles gives UDF=1, DV=0 and DQ holding 16. Pulse CLR_ERR: UDF=0. Write 20 and read 20 interleaved across the pointer wrap: data matches and pointers wrap 15->0.
4. Simultaneous at boundaries:
   - Full with WR=RD=1 and DI=0x55: COUNT stays 16 and 0x55 lands after the existing 16 entries.
   - Empty with WR=RD=1 and DI=0x33: COUNT=1, UDF=1, DV=0, and the next read returns 0x33.
5. Reset mid-operation: with COUNT=7, assert INIT together with WR=RD=1. Next cycle COUNT=0, EMPTY=1, DV=0, DQ=0 and OVF/UDF=0. A subsequent write/read of 0x5A returns 0x5A.
6. Parameter sweep: W=1/AW=1 and W=16/AW=5 with AF_LVL=D and AE_LVL=0. Randomised WR/RD for 2000 cycles against a scoreboard model; COUNT, flags and data match every cycle.
